det_sched: RTL and testbench

DET_SCHED -- requirements
Module: det_sched

---
 rtl/det_sched.sv | 84 ++++++++
 tb/tb_det_sched.sv | 114 +++++++++++
 2 files changed

// File: rtl/det_sched.sv
// det_sched: run-length detector time-shared between two serial channels.
// Optional build macro DET_SCHED_SLOT_LIMIT_EN caps each grant at 8 sampled bits.
module det_sched (
    input  logic [0:0]  KEY,
    input  logic [8:0]  SW,
    output logic [2:0]  LEDG,
    output logic [17:0] LEDR
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, SWITCH = 2'b10} state_t;

    logic       clk, rst, d0, d1, r0, r1;
    logic [3:0] n;
    state_t     state, nxt;
    logic       grant, ptr, prev, z;
    logic [3:0] run, scnt, neff, nrun;
    logic [7:0] c0, c1;
    logic       bit_g, req_g, hit, last;

    assign clk   = KEY[0];
    assign rst   = SW[0];
    assign d0    = SW[1];
    assign d1    = SW[2];
    assign r0    = SW[3];
    assign r1    = SW[4];
    assign n     = SW[8:5];
    assign neff  = n < 4'd2 ? 4'd2 : n;
    assign bit_g = grant ? d1 : d0;
    assign req_g = grant ? r1 : r0;
    assign nrun  = (scnt == 4'd0 || bit_g != prev) ? 4'd1 : (run == 4'd15 ? 4'd15 : run + 4'd1);
    assign hit   = nrun >= neff;
`ifdef DET_SCHED_SLOT_LIMIT_EN
    assign last  = scnt == 4'd7;
`else
    assign last  = 1'b0;
`endif

    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : nxt;

    // next state: grant ends when its request drops or the slot fills
    always_comb
        nxt = state == IDLE ? ((r0 | r1) ? RUN : IDLE) :
              state == RUN  ? ((!req_g || last) ? SWITCH : RUN) : IDLE;

    // grant, pointer, run tracking, detection flag and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            grant <= 1'b0;
            ptr   <= 1'b1;
            prev  <= 1'b0;
            z     <= 1'b0;
            run   <= 4'd0;
            scnt  <= 4'd0;
            c0    <= 8'd0;
            c1    <= 8'd0;
        end else begin
            z <= 1'b0;
            case (state)
                IDLE: if (r0 | r1) begin
                    grant <= (r0 & r1) ? ~ptr : r1;
                    run   <= 4'd0;
                    scnt  <= 4'd0;
                end
                RUN: if (req_g) begin
                    run  <= nrun;
                    prev <= bit_g;
                    scnt <= scnt + {3'b000, scnt != 4'd15};
                    z    <= hit;
                    if (hit && !grant && c0 != 8'hff) c0 <= c0 + 8'd1;
                    if (hit && grant && c1 != 8'hff) c1 <= c1 + 8'd1;
                end
                SWITCH: ptr <= grant;
                default: ;
            endcase
        end
    end

    // outputs
    always_comb begin
        LEDG = {state == RUN, grant, z};
        LEDR = {state, c1, c0};
    end
endmodule

// File: tb/tb_det_sched.sv
// tb_det_sched: scoreboard bench for det_sched with directed vectors.
module tb_det_sched;
    typedef struct {
        string       nm;
        logic [2:0]  g;
        logic [17:0] r;
    } exp_t;

    logic        clk = 1'b0;
    logic [8:0]  SW = 9'd0;
    logic [2:0]  LEDG;
    logic [17:0] LEDR;
    exp_t        q[$];
    exp_t        e;
    int          passed = 0;
    int          total = 0;

    det_sched dut (.KEY(clk), .SW(SW), .LEDG(LEDG), .LEDR(LEDR));

    always #5 clk = ~clk;

    function automatic logic [8:0] mk(input logic rst, input logic d0, input logic d1,
                                      input logic r0, input logic r1, input logic [3:0] n);
        return {n, r1, r0, d1, d0, rst};
    endfunction

    // one clock: drive at negedge, queue expected outputs after the rising edge
    task automatic cyc(input logic [8:0] sw, input bit chk, input logic [2:0] eg,
                       input logic [17:0] er, input string nm);
        @(negedge clk);
        SW = sw;
        @(posedge clk);
        #1;
        if (chk) q.push_back('{nm, eg, er});
    endtask

    // monitor: compare every queued expectation at the following falling edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (LEDG !== e.g || LEDR !== e.r)
                $display("FAIL %s: got LEDG=%b LEDR=%h, want LEDG=%b LEDR=%h", e.nm, LEDG, LEDR, e.g, e.r);
            else
                passed++;
        end
    end

    initial begin
        logic [8:0]  s;
        logic [7:0]  c;
        cyc(mk(1,0,0,0,0,0), 1, 3'b000, 18'h00000, "reset");
        s = mk(0,0,0,1,0,4);
        cyc(s, 1, 3'b100, 18'h10000, "r30_enter");
        cyc(s, 1, 3'b100, 18'h10000, "r30_b1");
        cyc(s, 1, 3'b100, 18'h10000, "r30_b2");
        cyc(s, 1, 3'b100, 18'h10000, "r30_b3");
        cyc(s, 1, 3'b101, 18'h10001, "r30_b4");
        cyc(s, 1, 3'b101, 18'h10002, "r30_b5");
        cyc(mk(0,0,0,0,0,4), 1, 3'b000, 18'h20002, "r30_switch");
        cyc(mk(0,0,0,0,0,4), 1, 3'b000, 18'h00002, "r30_idle");
        s = mk(0,0,1,0,1,0);
        cyc(s, 1, 3'b110, 18'h10002, "r31_enter");
        cyc(s, 1, 3'b110, 18'h10002, "r31_b1");
        cyc(s, 1, 3'b111, 18'h10102, "r31_b2");
        s = mk(0,0,0,0,1,0);
        cyc(s, 1, 3'b110, 18'h10102, "r31_b3");
        cyc(s, 1, 3'b111, 18'h10202, "r31_b4");
        cyc(mk(0,0,0,0,0,0), 1, 3'b010, 18'h20202, "r31_switch");
        cyc(mk(0,0,0,0,0,0), 1, 3'b010, 18'h00202, "r31_idle_hold_grant");
        s = mk(0,0,0,1,0,2);
        cyc(s, 1, 3'b100, 18'h10202, "mid_enter");
        cyc(s, 1, 3'b100, 18'h10202, "mid_b1");
        cyc(s, 1, 3'b101, 18'h10203, "mid_b2");
        cyc(mk(1,0,0,1,0,2), 1, 3'b000, 18'h00000, "mid_run_reset");
`ifdef DET_SCHED_SLOT_LIMIT_EN
        s = mk(0,0,0,1,1,15);
        for (int k = 0; k < 30; k++) begin
            int ph;
            ph = k % 10;
            cyc(s, 1, {ph < 8, ((k / 10) % 2) == 1, 1'b0},
                {(ph < 8) ? 2'b01 : (ph == 8 ? 2'b10 : 2'b00), 16'h0000}, "slot_alternate");
        end
`else
        s = mk(0,1,0,1,1,15);
        cyc(s, 1, 3'b100, 18'h10000, "r32_tie_ch0");
        for (int k = 0; k < 3; k++) cyc(s, 1, 3'b100, 18'h10000, "r32_no_preempt");
        s = mk(0,1,0,0,1,15);
        cyc(s, 1, 3'b000, 18'h20000, "r32_switch");
        cyc(s, 1, 3'b000, 18'h00000, "r32_idle");
        cyc(s, 1, 3'b110, 18'h10000, "r32_ch1");
        s = mk(0,0,0,1,1,15);
        for (int k = 0; k < 12; k++) cyc(s, 1, 3'b110, 18'h10000, "r34_keep_grant");
        s = mk(0,0,0,1,0,15);
        cyc(s, 1, 3'b010, 18'h20000, "ptr_switch");
        cyc(mk(0,0,0,1,1,15), 1, 3'b010, 18'h00000, "ptr_idle");
        cyc(mk(0,0,0,1,1,15), 1, 3'b100, 18'h10000, "ptr_tie_ch0");
        cyc(mk(1,0,0,0,0,0), 1, 3'b000, 18'h00000, "sat_reset");
        s = mk(0,1,0,1,0,2);
        cyc(s, 1, 3'b100, 18'h10000, "sat_enter");
        for (int k = 1; k <= 305; k++) begin
            c = (k - 1 > 255) ? 8'hff : 8'(k - 1);
            cyc(s, k <= 3 || k >= 254, {1'b1, 1'b0, k >= 2}, {10'h100, c}, "sat_count");
        end
`endif
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) $display("FAIL drain: %0d left, want 0", q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
